sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer that sits directly downstream of the D flip-flop stage. It samples the flip-flop's `q` output one bit per strobe, assembles `WIDTH`-bit words, and presents each completed word through a one-entry valid/ready holding register. A sticky flag reports any word lost because the consumer did not drain the holding register in time.

---
 rtl/sipo_deser_if.sv | 31 +++
 rtl/sipo_deser.sv | 66 ++++++
 tb/tb_sipo_deser.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: bundles the serial input side and the parallel output side of sipo_deser
//   din        serial bit from the upstream flip-flop q
//   din_en     bit strobe
//   start      frame start
//   dout       completed word in the holding register
//   dout_valid holding register has an unconsumed word
//   dout_ready consumer accepts the word
//   busy       deserializer is mid-frame
//   bit_cnt    bits captured in the current frame
//   overrun    sticky word-dropped flag
interface sipo_deser_if #(
   parameter int WIDTH = 8
);
   logic                         din;
   logic                         din_en;
   logic                         start;
   logic [WIDTH-1:0]             dout;
   logic                         dout_valid;
   logic                         dout_ready;
   logic                         busy;
   logic [$clog2(WIDTH+1)-1:0]   bit_cnt;
   logic                         overrun;
   modport master (
      output din, din_en, start, dout_ready,
      input  dout, dout_valid, busy, bit_cnt, overrun
   );
   modport slave (
      input  din, din_en, start, dout_ready,
      output dout, dout_valid, busy, bit_cnt, overrun
   );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with one-entry valid/ready holding register
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    sipo_deser_if slave: din/din_en/start in, dout/dout_valid/dout_ready handshake,
//          busy/bit_cnt/overrun status
module sipo_deser #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input logic         clk,
   input logic         rst_n,
   sipo_deser_if.slave bus
);
   localparam int CW = $clog2(WIDTH+1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] next_sreg;
   logic [CW-1:0]    cnt_base;
   logic [CW-1:0]    next_cnt;
   logic             shift;
   logic             done;
   // start restarts the frame, so a same-cycle strobe shifts into a cleared register
   always_comb begin
      base      = bus.start ? '0 : sreg;
      cnt_base  = bus.start ? '0 : bus.bit_cnt;
      shift     = bus.din_en && (bus.start || state == SHIFT);
      next_sreg = MSB_FIRST != 0 ? {base[WIDTH-2:0], bus.din} : {bus.din, base[WIDTH-1:1]};
      next_cnt  = cnt_base + CW'(1);
      done      = shift && next_cnt == CW'(WIDTH);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         sreg           <= '0;
         bus.bit_cnt    <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         if (bus.start) begin
            state       <= SHIFT;
            sreg        <= '0;
            bus.bit_cnt <= '0;
         end
         if (shift) begin
            sreg        <= next_sreg;
            bus.bit_cnt <= done ? '0 : next_cnt;
            if (done) state <= IDLE;
         end
         // a completing word wins over a plain consume, so a same-cycle handshake has no bubble
         if (done) begin
            if (!bus.dout_valid || bus.dout_ready) begin
               bus.dout       <= next_sreg;
               bus.dout_valid <= 1'b1;
            end else begin
               bus.overrun <= 1'b1;
            end
         end else if (bus.dout_valid && bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
         end
      end
   end
   assign bus.busy = state == SHIFT;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench driving an MSB-first and an LSB-first sipo_deser in parallel
//   clk/rst_n and the serial/handshake inputs are shared by both instances
module tb_sipo_deser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din = 1'b0;
   logic din_en = 1'b0;
   logic start = 1'b0;
   logic dout_ready = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   sipo_deser_if #(.WIDTH(8)) bm ();
   sipo_deser_if #(.WIDTH(8)) bl ();
   assign bm.din = din;
   assign bm.din_en = din_en;
   assign bm.start = start;
   assign bm.dout_ready = dout_ready;
   assign bl.din = din;
   assign bl.din_en = din_en;
   assign bl.start = start;
   assign bl.dout_ready = dout_ready;
   sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm));
   sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // sends the first n bits of w, leftmost bit first; ready is raised only with the last bit
   task automatic send(input logic [7:0] w, input int n, input bit st, input bit gaps, input bit rdy_last);
      for (int i = 0; i < n; i++) begin
         if (gaps && i != 0) begin
            din_en = 1'b0;
            start = 1'b0;
            dout_ready = 1'b0;
            repeat ($urandom_range(0, 3)) step();
         end
         din = w[7-i];
         din_en = 1'b1;
         start = st && i == 0;
         dout_ready = i == n - 1 ? rdy_last : 1'b0;
         step();
      end
      din_en = 1'b0;
      start = 1'b0;
      dout_ready = 1'b0;
   endtask
   task automatic drain();
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
   endtask
   initial begin
      step();
      step();
      check("rst_dout", bm.dout, 8'h00);
      check("rst_valid", bm.dout_valid, 0);
      check("rst_busy", bm.busy, 0);
      check("rst_cnt", bm.bit_cnt, 0);
      check("rst_ovr", bm.overrun, 0);
      rst_n = 1'b1;
      step();
      send(8'hA5, 8, 1, 0, 0);
      check("a5_m_dout", bm.dout, 8'hA5);
      check("a5_m_valid", bm.dout_valid, 1);
      check("a5_m_busy", bm.busy, 0);
      check("a5_m_cnt", bm.bit_cnt, 0);
      check("a5_l_dout", bl.dout, 8'hA5);
      drain();
      check("drain_valid", bm.dout_valid, 0);
      check("drain_dout", bm.dout, 8'hA5);
      send(8'hA5, 8, 1, 1, 0);
      check("gap_l_dout", bl.dout, 8'hA5);
      check("gap_l_valid", bl.dout_valid, 1);
      drain();
      send(8'h01, 8, 1, 0, 0);
      check("ord_m_dout", bm.dout, 8'h01);
      check("ord_l_dout", bl.dout, 8'h80);
      drain();
      send(8'h3C, 8, 1, 0, 0);
      send(8'hC3, 8, 1, 0, 0);
      check("ovr_dout", bm.dout, 8'h3C);
      check("ovr_valid", bm.dout_valid, 1);
      check("ovr_flag", bm.overrun, 1);
      drain();
      check("ovr_drain_valid", bm.dout_valid, 0);
      check("ovr_sticky", bm.overrun, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst2_ovr", bm.overrun, 0);
      send(8'h3C, 8, 1, 0, 0);
      send(8'hC3, 8, 1, 0, 1);
      check("hs_dout", bm.dout, 8'hC3);
      check("hs_valid", bm.dout_valid, 1);
      check("hs_ovr", bm.overrun, 0);
      drain();
      send(8'h15, 5, 1, 0, 0);
      check("part_cnt", bm.bit_cnt, 5);
      check("part_busy", bm.busy, 1);
      send(8'hFF, 8, 1, 0, 0);
      check("restart_dout", bm.dout, 8'hFF);
      check("restart_ovr", bm.overrun, 0);
      drain();
      check("restart_nowd", bm.dout_valid, 0);
      send(8'hF0, 4, 1, 0, 0);
      check("mid_cnt", bm.bit_cnt, 4);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mr_dout", bm.dout, 8'h00);
      check("mr_valid", bm.dout_valid, 0);
      check("mr_busy", bm.busy, 0);
      check("mr_cnt", bm.bit_cnt, 0);
      send(8'h81, 8, 1, 0, 0);
      check("post_m_dout", bm.dout, 8'h81);
      check("post_l_dout", bl.dout, 8'h81);
      check("post_valid", bm.dout_valid, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
